sprite_engine: RTL and testbench
================================

# sprite_engine

Multi-sprite motion and pixel-hit engine for the VGA game pipeline; a parametrised successor to the single-duck sprite block. It holds up to NUM_SPRITES independent sprites, each with a position, a velocity and an active flag. Every frame it advances and bounces all active sprites, and every pixel it reports which sprite (if any) covers DrawX/DrawY along with its ROM address. It accepts spawn requests from game control and resolves shots against live sprites; it sits between the VGA controller and the color mapper.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprite slots (1..8)
- SPR_W, 64, sprite width in pixels (power of two)
- SPR_H, 64, sprite height in pixels (power of two)
- VEL_W, 4, signed per-axis velocity width, pixels/frame
- ADDR_W, 19, sprite ROM address width

Ports:
- Clk  in  1  system clock (50 MHz); the only clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA_VS, sampled as data in the Clk domain
- DrawX, DrawY  in  10 each  current pixel coordinates
- spawn_valid  in  1  spawn request
- spawn_ready  out  1  a free slot exists
- spawn_x, spawn_y  in  10 each  initial top-left position
- spawn_vx, spawn_vy  in  VEL_W each  signed initial velocity
- shot_valid  in  1  one-cycle shot strobe
- shot_x, shot_y  in  10 each  crosshair position
- hit_valid  out  1  one-cycle pulse: the shot killed a sprite
- hit_id  out  $clog2(NUM_SPRITES)  index of the killed sprite
- is_sprite  out  1  current pixel lies inside an active sprite
- sprite_id  out  $clog2(NUM_SPRITES)  index of the covering sprite
- sprite_addr  out  ADDR_W  id*SPR_W*SPR_H + row*SPR_W + col
- active_count  out  $clog2(NUM_SPRITES+1)  number of active slots

## Operation
- Slot state: x and y (10 b unsigned), vx and vy (VEL_W signed), active (1 b). Reset clears all slots to 0 and inactive.
- Frame tick: two-flop edge detect on frame_clk. The tick fires one Clk after the rising edge is seen.
- Motion on each tick, for each active slot:
  - Compute nx = x + sign-extended vx.
  - If nx < 0, then x = 0 and vx = -vx.
  - If nx > SCREEN_W-SPR_W, then x = SCREEN_W-SPR_W and vx = -vx.
  - Otherwise x = nx. The y axis follows the same rule with SCREEN_H-SPR_H.
  - Use 12-bit signed intermediates. vx = -2^(VEL_W-1) saturates to +2^(VEL_W-1)-1 on negate.
- Spawn:
  - spawn_ready = !Reset && any slot inactive.
  - A request is accepted on spawn_valid && spawn_ready. It writes the lowest-index inactive slot and sets it active.
  - Positions are clamped into the legal range on load.
- Shot:
  - On shot_valid, test every active slot for x <= shot_x < x+SPR_W and y <= shot_y < y+SPR_H.
  - The lowest matching index wins: that slot is cleared to inactive, hit_valid pulses with hit_id.
  - No match gives no pulse.
- Pixel: the lowest-index active slot covering (DrawX, DrawY) drives sprite_id and sprite_addr. If none, is_sprite = 0, sprite_id = 0, sprite_addr = 0.
- Simultaneous events in one cycle, applied against pre-cycle state:
  - Shot kill beats motion; a killed slot is not moved.
  - A slot freed by a shot is not spawnable until the next cycle.
  - A slot spawned on a tick cycle takes its spawn values and moves from the next tick.
- Reset mid-operation: all slots inactive and all outputs 0 on the next edge. Pending hit and pixel registers are discarded.

## Timing
- All outputs except spawn_ready are registered. Reset values are 0; spawn_ready is 0 while Reset is high.
- Pixel path latency is 1 Clk, from DrawX/DrawY to is_sprite/sprite_id/sprite_addr.
- Shot latency is 1 Clk, from shot_valid to hit_valid. Back-to-back shots on consecutive cycles are each resolved.
- A spawn is visible on the pixel path and in active_count 1 Clk after acceptance.
- A position update is visible 1 Clk after the tick, i.e. 2 Clk after the frame_clk rising edge is sampled.

## Structure
- sprite_pkg:
  - SCREEN_W = 640, SCREEN_H = 480.
  - typedef struct sprite_state_t {x, y, vx, vy, active}.
  - Function clamp_pos.
- sub-module sprite_slot (one per sprite), containing the state register and the motion/bounce, hit-test and cover-test logic.
- The top level holds the tick detect, free-slot priority encoder, shot and pixel priority encoders, address compute and popcount.

## Test plan
- Reset, then spawn (100,100,+3,-2) -> slot 0 active, active_count = 1; after one tick x = 103, y = 98.
- Spawn x = 570, vx = +7, then one tick -> x = 576, vx = -7.
- Fill all 4 slots -> spawn_ready = 0; shot at the centre of slot 2 -> hit_valid with hit_id = 2, next cycle spawn_ready = 1, and the next spawn lands in slot 2.
- Slots 0 and 1 overlapping at (200,200), pixel (210,210) -> is_sprite = 1, sprite_id = 0, sprite_addr = 10*64+10 = 650, one Clk later.
- Shot and tick in the same cycle on slot 1 -> slot 1 is killed and not moved; other slots advance.
- Assert Reset while 3 slots are active and a shot is pending -> next cycle all outputs 0, hit_valid never pulses.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared screen geometry, per-slot state record and position clamp for the sprite engine.
package sprite_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int MAX_VEL_W = 8;

    typedef struct packed {
        logic [9:0]                  x;
        logic [9:0]                  y;
        logic signed [MAX_VEL_W-1:0] vx;
        logic signed [MAX_VEL_W-1:0] vy;
        logic                        active;
    } sprite_state_t;

    function automatic logic [9:0] clamp_pos(input logic [9:0] pos, input logic [9:0] max_pos);
        return (pos > max_pos) ? max_pos : pos;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: state register, per-frame motion with wall bounce, shot hit test and pixel cover test.
module sprite_slot
    import sprite_pkg::*;
#(
    parameter int  SPR_W = 64,
    parameter int  SPR_H = 64,
    parameter int  VEL_W = 4,
    localparam int COL_W = $clog2(SPR_W),
    localparam int ROW_W = $clog2(SPR_H)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tick_i,
    input  logic             spawn_we_i,
    input  logic [9:0]       spawn_x_i,
    input  logic [9:0]       spawn_y_i,
    input  logic [VEL_W-1:0] spawn_vx_i,
    input  logic [VEL_W-1:0] spawn_vy_i,
    input  logic             kill_i,
    input  logic [9:0]       shot_x_i,
    input  logic [9:0]       shot_y_i,
    input  logic [9:0]       draw_x_i,
    input  logic [9:0]       draw_y_i,
    output logic             active_o,
    output logic             shot_hit_o,
    output logic             covers_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o
);

    localparam logic [9:0] X_MAX   = 10'(SCREEN_W - SPR_W);
    localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - SPR_H);
    localparam int         VEL_MAX = 2 ** (VEL_W - 1) - 1;
    localparam int         VEL_MIN = -(2 ** (VEL_W - 1));

    sprite_state_t state_q, state_d;

    // The most negative velocity has no positive twin, so it saturates on reflection.
    function automatic logic signed [MAX_VEL_W-1:0] neg_vel(input logic signed [MAX_VEL_W-1:0] v);
        if (int'(v) == VEL_MIN) return MAX_VEL_W'(VEL_MAX);
        return -v;
    endfunction

    function automatic void step_axis(
        input  logic [9:0]                  pos,
        input  logic signed [MAX_VEL_W-1:0] vel,
        input  logic [9:0]                  lim,
        output logic [9:0]                  pos_n,
        output logic signed [MAX_VEL_W-1:0] vel_n
    );
        logic signed [11:0] np;
        np    = $signed({2'b00, pos}) + 12'(vel);
        pos_n = pos;
        vel_n = vel;
        if (np < 0) begin
            pos_n = '0;
            vel_n = neg_vel(vel);
        end else if (np > $signed({2'b00, lim})) begin
            pos_n = lim;
            vel_n = neg_vel(vel);
        end else begin
            pos_n = np[9:0];
        end
    endfunction

    function automatic logic in_box(
        input logic [9:0] px,
        input logic [9:0] py,
        input logic [9:0] bx,
        input logic [9:0] by
    );
        return (px >= bx) && ({1'b0, px} < ({1'b0, bx} + 11'(SPR_W))) &&
               (py >= by) && ({1'b0, py} < ({1'b0, by} + 11'(SPR_H)));
    endfunction

    always_comb begin
        // NOTE: start from the held value so every branch assigns state_d and no latch is inferred.
        state_d = state_q;
        if (kill_i) begin
            state_d.active = 1'b0;
        end else if (spawn_we_i) begin
            state_d.x      = clamp_pos(spawn_x_i, X_MAX);
            state_d.y      = clamp_pos(spawn_y_i, Y_MAX);
            state_d.vx     = MAX_VEL_W'($signed(spawn_vx_i));
            state_d.vy     = MAX_VEL_W'($signed(spawn_vy_i));
            state_d.active = 1'b1;
        end else if (tick_i && state_q.active) begin
            step_axis(state_q.x, state_q.vx, X_MAX, state_d.x, state_d.vx);
            step_axis(state_q.y, state_q.vy, Y_MAX, state_d.y, state_d.vy);
        end
    end

    // NOTE: sequential state uses non-blocking assignment; the synchronous reset clears the whole record.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= '0;
        else         state_q <= state_d;
    end

    assign active_o   = state_q.active;
    assign shot_hit_o = state_q.active && in_box(shot_x_i, shot_y_i, state_q.x, state_q.y);
    assign covers_o   = state_q.active && in_box(draw_x_i, draw_y_i, state_q.x, state_q.y);
    assign row_o      = ROW_W'(draw_y_i - state_q.y);
    assign col_o      = COL_W'(draw_x_i - state_q.x);

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite motion and pixel-hit engine: frame tick detect, slot arbitration for spawn/shot/pixel,
// ROM address compute and live-slot count.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int  NUM_SPRITES = 4,
    parameter int  SPR_W       = 64,
    parameter int  SPR_H       = 64,
    parameter int  VEL_W       = 4,
    parameter int  ADDR_W      = 19,
    localparam int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int CNT_W       = $clog2(NUM_SPRITES + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              spawn_valid,
    output logic              spawn_ready,
    input  logic [9:0]        spawn_x,
    input  logic [9:0]        spawn_y,
    input  logic [VEL_W-1:0]  spawn_vx,
    input  logic [VEL_W-1:0]  spawn_vy,
    input  logic              shot_valid,
    input  logic [9:0]        shot_x,
    input  logic [9:0]        shot_y,
    output logic              hit_valid,
    output logic [ID_W-1:0]   hit_id,
    output logic              is_sprite,
    output logic [ID_W-1:0]   sprite_id,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic [CNT_W-1:0]  active_count
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    logic fs_q, prev_q, tick_q;

    // frame_clk is sampled as data; the registered edge moves sprites two Clk after it is first seen.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs_q   <= 1'b0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            fs_q   <= frame_clk;
            prev_q <= fs_q;
            tick_q <= fs_q & ~prev_q;
        end
    end

    logic [NUM_SPRITES-1:0] active, shot_hit, covers, spawn_we, kill, active_next;
    logic [ROW_W-1:0]       row [NUM_SPRITES];
    logic [COL_W-1:0]       col [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        sprite_slot #(
            .SPR_W(SPR_W),
            .SPR_H(SPR_H),
            .VEL_W(VEL_W)
        ) u_slot (
            .clk_i     (Clk),
            .reset_i   (Reset),
            .tick_i    (tick_q),
            .spawn_we_i(spawn_we[g]),
            .spawn_x_i (spawn_x),
            .spawn_y_i (spawn_y),
            .spawn_vx_i(spawn_vx),
            .spawn_vy_i(spawn_vy),
            .kill_i    (kill[g]),
            .shot_x_i  (shot_x),
            .shot_y_i  (shot_y),
            .draw_x_i  (DrawX),
            .draw_y_i  (DrawY),
            .active_o  (active[g]),
            .shot_hit_o(shot_hit[g]),
            .covers_o  (covers[g]),
            .row_o     (row[g]),
            .col_o     (col[g])
        );
    end

    logic              free_found, hit_found, cov_found, spawn_accept, shot_kill;
    logic [ID_W-1:0]   free_idx, hit_idx, cov_idx;
    logic [ROW_W-1:0]  row_sel;
    logic [COL_W-1:0]  col_sel;
    logic [ADDR_W-1:0] sprite_addr_d;
    logic [CNT_W-1:0]  active_count_d;

    // Descending scans leave the lowest matching index in each encoder.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        hit_found  = 1'b0;
        hit_idx    = '0;
        cov_found  = 1'b0;
        cov_idx    = '0;
        row_sel    = '0;
        col_sel    = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = ID_W'(i);
            end
            if (shot_hit[i]) begin
                hit_found = 1'b1;
                hit_idx   = ID_W'(i);
            end
            if (covers[i]) begin
                cov_found = 1'b1;
                cov_idx   = ID_W'(i);
                row_sel   = row[i];
                col_sel   = col[i];
            end
        end
    end

    assign spawn_ready  = !Reset && free_found;
    assign spawn_accept = spawn_valid && spawn_ready;
    assign shot_kill    = shot_valid && hit_found;

    always_comb begin
        spawn_we       = '0;
        kill           = '0;
        active_next    = '0;
        active_count_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            spawn_we[i]    = spawn_accept && (free_idx == ID_W'(i));
            kill[i]        = shot_kill && (hit_idx == ID_W'(i));
            active_next[i] = (active[i] && !kill[i]) || spawn_we[i];
            active_count_d = active_count_d + CNT_W'(active_next[i]);
        end
    end

    assign sprite_addr_d = ADDR_W'(int'(cov_idx) * SPR_W * SPR_H + int'(row_sel) * SPR_W + int'(col_sel));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_valid    <= 1'b0;
            hit_id       <= '0;
            is_sprite    <= 1'b0;
            sprite_id    <= '0;
            sprite_addr  <= '0;
            active_count <= '0;
        end else begin
            hit_valid    <= shot_kill;
            hit_id       <= shot_kill ? hit_idx : '0;
            is_sprite    <= cov_found;
            sprite_id    <= cov_idx;
            sprite_addr  <= sprite_addr_d;
            active_count <= active_count_d;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed scoreboard bench for sprite_engine: spawn, motion/bounce, shots, pixel priority and reset.
module tb_sprite_engine;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [9:0]  spawn_x = '0, spawn_y = '0;
    logic [3:0]  spawn_vx = '0, spawn_vy = '0;
    logic        shot_valid = 1'b0;
    logic [9:0]  shot_x = '0, shot_y = '0;
    logic        hit_valid;
    logic [1:0]  hit_id;
    logic        is_sprite;
    logic [1:0]  sprite_id;
    logic [18:0] sprite_addr;
    logic [2:0]  active_count;

    sprite_engine dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_vx    (spawn_vx),
        .spawn_vy    (spawn_vy),
        .shot_valid  (shot_valid),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .hit_valid   (hit_valid),
        .hit_id      (hit_id),
        .is_sprite   (is_sprite),
        .sprite_id   (sprite_id),
        .sprite_addr (sprite_addr),
        .active_count(active_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        is;
        logic [1:0]  id;
        logic [18:0] addr;
    } pix_exp_t;

    typedef struct {
        logic       v;
        logic [1:0] id;
    } hit_exp_t;

    pix_exp_t pix_q[$];
    hit_exp_t hit_q[$];
    int n_asserts = 0;
    int n_fails   = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        check("ready_in_reset", 32'(spawn_ready), 0);
        Reset = 1'b0;
        step();
        check("count_after_reset", 32'(active_count), 0);
        check("ready_after_reset", 32'(spawn_ready), 1);
    endtask

    task automatic spawn(input int x, input int y, input int vx, input int vy);
        spawn_valid = 1'b1;
        spawn_x     = 10'(x);
        spawn_y     = 10'(y);
        spawn_vx    = 4'(vx);
        spawn_vy    = 4'(vy);
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic is, input int id, input int addr);
        pix_exp_t e;
        e.is   = is;
        e.id   = 2'(id);
        e.addr = 19'(addr);
        pix_q.push_back(e);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        e = pix_q.pop_front();
        check({tag, "_is"}, 32'(is_sprite), 32'(e.is));
        check({tag, "_id"}, 32'(sprite_id), 32'(e.id));
        check({tag, "_addr"}, 32'(sprite_addr), 32'(e.addr));
    endtask

    task automatic shoot(input string tag, input int x, input int y, input logic hit, input int id);
        hit_exp_t e;
        e.v  = hit;
        e.id = 2'(id);
        hit_q.push_back(e);
        shot_valid = 1'b1;
        shot_x     = 10'(x);
        shot_y     = 10'(y);
        step();
        shot_valid = 1'b0;
        e = hit_q.pop_front();
        check({tag, "_valid"}, 32'(hit_valid), 32'(e.v));
        if (e.v) check({tag, "_id"}, 32'(hit_id), 32'(e.id));
    endtask

    // After frame_begin the next Clk edge is the one that applies motion.
    task automatic frame_begin();
        frame_clk = 1'b1;
        step();
        step();
    endtask

    task automatic frame_end();
        frame_clk = 1'b0;
        step();
        step();
    endtask

    task automatic tick();
        frame_begin();
        step();
        frame_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset();
        check("reset_hit_valid", 32'(hit_valid), 0);
        check("reset_is_sprite", 32'(is_sprite), 0);
        check("reset_addr", 32'(sprite_addr), 0);

        // Basic spawn and one frame of motion.
        spawn(100, 100, 3, -2);
        check("spawn_count", 32'(active_count), 1);
        probe("s0_tl", 100, 100, 1'b1, 0, 0);
        probe("s0_br", 163, 163, 1'b1, 0, 4095);
        probe("s0_right", 164, 100, 1'b0, 0, 0);
        tick();
        probe("s0_moved", 103, 98, 1'b1, 0, 0);
        probe("s0_old_edge", 102, 98, 1'b0, 0, 0);
        probe("s0_moved_br", 166, 161, 1'b1, 0, 4095);

        // Right-wall bounce, then travel back with the reflected velocity.
        do_reset();
        spawn(570, 300, 7, 0);
        tick();
        probe("bounce_r", 576, 300, 1'b1, 0, 0);
        probe("bounce_r_left", 575, 300, 1'b0, 0, 0);
        tick();
        probe("after_bounce", 569, 300, 1'b1, 0, 0);
        probe("after_bounce_left", 568, 300, 1'b0, 0, 0);

        // Low-wall bounce with saturated negate, and clamp on load.
        do_reset();
        spawn(5, 3, -8, -8);
        spawn(700, 470, 0, 0);
        probe("clamp_tl", 576, 416, 1'b1, 1, 4096);
        probe("clamp_br", 639, 479, 1'b1, 1, 8191);
        tick();
        probe("bounce_lo", 0, 0, 1'b1, 0, 0);
        tick();
        probe("sat_vel", 7, 7, 1'b1, 0, 0);
        probe("sat_vel_x", 6, 7, 1'b0, 0, 0);
        probe("sat_vel_y", 7, 6, 1'b0, 0, 0);
        probe("still_s1", 576, 416, 1'b1, 1, 4096);

        // Fill all slots, refused spawn, shot kill with simultaneous spawn attempt, refill.
        do_reset();
        spawn(0, 0, 0, 0);
        spawn(100, 0, 0, 0);
        spawn(200, 0, 0, 0);
        spawn(300, 0, 0, 0);
        check("full_count", 32'(active_count), 4);
        check("full_ready", 32'(spawn_ready), 0);
        spawn(500, 400, 0, 0);
        check("refused_count", 32'(active_count), 4);
        spawn_valid = 1'b1;
        spawn_x     = 10'd450;
        spawn_y     = 10'd300;
        shoot("kill2", 232, 32, 1'b1, 2);
        spawn_valid = 1'b0;
        check("freed_ready", 32'(spawn_ready), 1);
        check("freed_count", 32'(active_count), 3);
        step();
        check("hit_one_cycle", 32'(hit_valid), 0);
        spawn(400, 200, 0, 0);
        check("refill_count", 32'(active_count), 4);
        probe("refill_slot2", 400, 200, 1'b1, 2, 8192);
        probe("no_ghost_spawn", 450, 300, 1'b0, 0, 0);
        shoot("miss_edge", 64, 10, 1'b0, 0);
        shoot("b2b_first", 63, 63, 1'b1, 0);
        shoot("b2b_second", 100, 0, 1'b1, 1);
        shoot("dead_slot", 100, 0, 1'b0, 0);
        check("after_b2b_count", 32'(active_count), 2);

        // Overlap priority and address.
        do_reset();
        spawn(200, 200, 0, 0);
        spawn(200, 200, 0, 0);
        probe("overlap", 210, 210, 1'b1, 0, 650);
        shoot("overlap_kill", 205, 205, 1'b1, 0);
        probe("overlap_s1", 210, 210, 1'b1, 1, 4746);

        // Shot, spawn and tick in the same cycle.
        do_reset();
        spawn(100, 100, 1, 1);
        spawn(300, 100, 1, 1);
        spawn(100, 300, 2, 0);
        frame_begin();
        spawn_valid = 1'b1;
        spawn_x     = 10'd400;
        spawn_y     = 10'd400;
        spawn_vx    = 4'd1;
        spawn_vy    = 4'd1;
        shoot("tick_kill1", 320, 120, 1'b1, 1);
        spawn_valid = 1'b0;
        frame_end();
        check("tick_kill_count", 32'(active_count), 3);
        probe("tk_s0_moved", 101, 101, 1'b1, 0, 0);
        probe("tk_s0_old", 100, 100, 1'b0, 0, 0);
        probe("tk_s1_gone", 310, 110, 1'b0, 0, 0);
        probe("tk_s2_moved", 102, 300, 1'b1, 2, 8192);
        probe("tk_s3_still", 400, 400, 1'b1, 3, 12288);

        // Reset in the same cycle as a hitting shot and a covered pixel.
        do_reset();
        spawn(50, 50, 0, 0);
        spawn(150, 50, 0, 0);
        spawn(250, 50, 0, 0);
        check("pre_rst_count", 32'(active_count), 3);
        begin
            hit_exp_t he;
            pix_exp_t pe;
            he.v = 1'b0; he.id = 2'd0;
            pe.is = 1'b0; pe.id = 2'd0; pe.addr = 19'd0;
            hit_q.push_back(he);
            pix_q.push_back(pe);
            DrawX = 10'd60; DrawY = 10'd60;
            shot_valid = 1'b1; shot_x = 10'd60; shot_y = 10'd60;
            Reset = 1'b1;
            step();
            he = hit_q.pop_front();
            pe = pix_q.pop_front();
            check("rst_hit_valid", 32'(hit_valid), 32'(he.v));
            check("rst_is_sprite", 32'(is_sprite), 32'(pe.is));
            check("rst_sprite_id", 32'(sprite_id), 32'(pe.id));
            check("rst_addr", 32'(sprite_addr), 32'(pe.addr));
            check("rst_count", 32'(active_count), 0);
            check("rst_ready", 32'(spawn_ready), 0);
            shot_valid = 1'b0;
            Reset = 1'b0;
            step();
            check("post_rst_hit", 32'(hit_valid), 0);
            check("post_rst_count", 32'(active_count), 0);
            check("post_rst_ready", 32'(spawn_ready), 1);
        end
        probe("post_rst_pix", 60, 60, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
